wphy_dfe_rx_dcoc: RTL and testbench

Receive-side DFE DC-offset-correction stage for the WiFi PHY, the RX counterpart of the DFE TX chain. Sits between the ADC sample interface and the RX baseband. Per I/Q branch it:
- estimates the DC offset with a two-speed leaky integrator;
- subtracts the estimate and saturates the result;
- buffers corrected samples in a small FIFO with a valid/ready handshake toward baseband.

---
 rtl/wphy_dfe_rx_dcoc.sv | 219 +++++++++++++++++++++
 tb/tb_wphy_dfe_rx_dcoc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wphy_dfe_rx_dcoc.sv
// Purpose : RX DC-offset correction. A two-speed leaky integrator estimates the I/Q DC offset,
//           the estimate is subtracted with saturation, and results are queued in a small FIFO.
//           Optional feature macro: WPHY_DFE_RX_DCOC_SAT_CNT_EN adds the sat_cnt output.
// Latency : adc_vld at cycle n -> pipeline register n+1 -> FIFO write n+1 -> out_vld n+2 (FIFO empty).
// Backpr. : the ADC side cannot be stalled. When the FIFO is full and not being read, the sample
//           is dropped and the sticky ovf flag is set.
// Ports   : clk, rst_n (async, active-low), en, freeze, adc_vld/adc_i/adc_q (ADC samples),
//           out_vld/out_rdy/out_i/out_q (to baseband), dc_i/dc_q (estimate), ovf, state,
//           sat_cnt (only with WPHY_DFE_RX_DCOC_SAT_CNT_EN).
module wphy_dfe_rx_dcoc #(
    parameter int DW         = 12,
    parameter int K_TRAIN    = 4,
    parameter int K_TRACK    = 8,
    parameter int TRAIN_LEN  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          freeze,
    input  logic          adc_vld,
    input  logic [DW-1:0] adc_i,
    input  logic [DW-1:0] adc_q,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_i,
    output logic [DW-1:0] out_q,
    output logic [DW-1:0] dc_i,
    output logic [DW-1:0] dc_q,
    output logic          ovf,
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
    output logic [15:0]   sat_cnt,
`endif
    output logic [1:0]    state
);

    localparam int AW = DW + K_TRACK + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = 10;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRAIN  = 2'd1,
        S_TRACK  = 2'd2,
        S_FREEZE = 2'd3
    } state_t;

    state_t               st;
    logic                 resume_track;   // state FREEZE returns to: 1 TRACK, 0 TRAIN
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc_i, acc_q;
    logic signed [AW-1:0] xi_ext, xq_ext;
    logic signed [AW-1:0] acc_i_nxt, acc_q_nxt;
    logic signed [DW:0]   yi, yq;
    logic                 take;
    logic                 train_done;

    function automatic logic [DW-1:0] sat_dw(input logic [DW:0] v);
        if (v[DW] ^ v[DW-1])
            sat_dw = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sat_dw = v[DW-1:0];
    endfunction

    assign take       = adc_vld && (st != S_IDLE);
    assign train_done = take && (cnt == CW'(TRAIN_LEN - 1));

    assign xi_ext = AW'($signed(adc_i));
    assign xq_ext = AW'($signed(adc_q));

    // Input is pre-scaled so the accumulator always sits at dc << K_TRACK,
    // whichever integrator speed is active.
    always_comb begin
        acc_i_nxt = acc_i + xi_ext - (acc_i >>> K_TRACK);
        acc_q_nxt = acc_q + xq_ext - (acc_q >>> K_TRACK);
        if (st == S_TRAIN) begin
            acc_i_nxt = acc_i + (xi_ext <<< (K_TRACK - K_TRAIN)) - (acc_i >>> K_TRAIN);
            acc_q_nxt = acc_q + (xq_ext <<< (K_TRACK - K_TRAIN)) - (acc_q >>> K_TRAIN);
        end
    end

    assign dc_i = DW'(acc_i >>> K_TRACK);
    assign dc_q = DW'(acc_q >>> K_TRACK);

    // Correction uses the estimate from before this sample's update.
    assign yi = $signed({adc_i[DW-1], adc_i}) - $signed({dc_i[DW-1], dc_i});
    assign yq = $signed({adc_q[DW-1], adc_q}) - $signed({dc_q[DW-1], dc_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= S_IDLE;
            resume_track <= 1'b0;
            cnt          <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
        end else if (!en) begin
            st           <= S_IDLE;
            resume_track <= 1'b0;
            cnt          <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    st           <= S_TRAIN;
                    cnt          <= '0;
                    resume_track <= 1'b0;
                end
                S_TRAIN: begin
                    if (take) begin
                        acc_i <= acc_i_nxt;
                        acc_q <= acc_q_nxt;
                        cnt   <= cnt + CW'(1);
                    end
                    if (freeze) begin
                        st           <= S_FREEZE;
                        resume_track <= train_done;
                    end else if (train_done) begin
                        st <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (take) begin
                        acc_i <= acc_i_nxt;
                        acc_q <= acc_q_nxt;
                    end
                    if (freeze) begin
                        st           <= S_FREEZE;
                        resume_track <= 1'b1;
                    end
                end
                S_FREEZE: begin
                    if (!freeze)
                        st <= resume_track ? S_TRACK : S_TRAIN;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign state = st;

    // Pipeline register and output FIFO.
    logic          p_vld;
    logic [DW-1:0] p_i, p_q;
    logic [DW-1:0] mem_i [FIFO_DEPTH];
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fcnt;
    logic          full, do_rd, do_wr;
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
    logic          p_sat;
`endif

    assign full    = (fcnt == DEPTH_C);
    assign out_vld = (fcnt != '0);
    assign do_rd   = out_vld && out_rdy;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr   = p_vld && (!full || do_rd);
    assign out_i   = out_vld ? mem_i[rd_ptr] : '0;
    assign out_q   = out_vld ? mem_q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_i[wr_ptr] <= p_i;
            mem_q[wr_ptr] <= p_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld   <= 1'b0;
            p_i     <= '0;
            p_q     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt    <= '0;
            ovf     <= 1'b0;
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
            p_sat   <= 1'b0;
            sat_cnt <= '0;
`endif
        end else if (!en) begin
            p_vld   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt    <= '0;
            ovf     <= 1'b0;
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
            sat_cnt <= '0;
`endif
        end else begin
            p_vld <= take;
            if (take) begin
                p_i <= sat_dw(yi);
                p_q <= sat_dw(yq);
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
                p_sat <= (yi[DW] ^ yi[DW-1]) | (yq[DW] ^ yq[DW-1]);
`endif
            end
            if (do_wr)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_wr && !do_rd)
                fcnt <= fcnt + (PW+1)'(1);
            else if (do_rd && !do_wr)
                fcnt <= fcnt - (PW+1)'(1);
            if (p_vld && !do_wr)
                ovf <= 1'b1;
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
            if (do_wr && p_sat && (sat_cnt != 16'hFFFF))
                sat_cnt <= sat_cnt + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_wphy_dfe_rx_dcoc.sv
module tb_wphy_dfe_rx_dcoc;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          freeze = 1'b0;
    logic          adc_vld = 1'b0;
    logic [DW-1:0] adc_i = '0;
    logic [DW-1:0] adc_q = '0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [DW-1:0] out_i, out_q, dc_i, dc_q;
    logic          ovf;
    logic [1:0]    state;
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
    logic [15:0]   sat_cnt;
`endif

    int checks = 0;
    int failures = 0;

    wphy_dfe_rx_dcoc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .freeze  (freeze),
        .adc_vld (adc_vld),
        .adc_i   (adc_i),
        .adc_q   (adc_q),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_i   (out_i),
        .out_q   (out_q),
        .dc_i    (dc_i),
        .dc_q    (dc_q),
        .ovf     (ovf),
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
        .sat_cnt (sat_cnt),
`endif
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input int q);
        adc_i = DW'(i);
        adc_q = DW'(q);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_i", $signed(out_i), 0);
        chk("rst_dc_i", $signed(dc_i), 0);
        chk("rst_dc_q", $signed(dc_q), 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_state", state, 0);
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
        chk("rst_sat_cnt", sat_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Constant input, TRAIN then TRACK, convergence
        en = 1'b1;
        tick();
        chk("idle_to_train", state, 1);
        set_x(100, -50);
        adc_vld = 1'b1;
        tick();                                   // sample 1
        chk("lat_no_vld_n1", out_vld, 0);
        chk("dc_i_first", $signed(dc_i), 6);      // (100<<4)>>>8
        chk("dc_q_first", $signed(dc_q), -4);     // floor(-800/256)
        tick();                                   // sample 2
        chk("lat_vld_n2", out_vld, 1);
        chk("out_i_first", $signed(out_i), 100);
        chk("out_q_first", $signed(out_q), -50);
        tick();                                   // sample 3
        chk("out_i_second", $signed(out_i), 94);
        chk("out_q_second", $signed(out_q), -46);
        repeat (60) tick();                       // 63 samples
        chk("train_at_63", state, 1);
        tick();                                   // 64 samples
        chk("track_at_64", state, 2);
        repeat (936) tick();                      // 1000 samples
        chk("conv_dc_i", $signed(dc_i), 100);
        chk("conv_dc_q", $signed(dc_q), -50);
        chk("conv_out_vld", out_vld, 1);
        chk("conv_out_i", $signed(out_i), 0);
        chk("conv_out_q", $signed(out_q), 0);
        adc_vld = 1'b0;
        repeat (3) tick();
        chk("drained", out_vld, 0);

        // Freeze during TRACK
        freeze = 1'b1;
        tick();
        chk("freeze_state", state, 3);
        set_x(500, -50);
        adc_vld = 1'b1;
        repeat (20) tick();
        adc_vld = 1'b0;
        tick();
        chk("frz_out_vld", out_vld, 1);
        chk("frz_out_i", $signed(out_i), 400);
        chk("frz_out_q", $signed(out_q), 0);
        chk("frz_dc_i", $signed(dc_i), 100);
        chk("frz_dc_q", $signed(dc_q), -50);
        freeze = 1'b0;
        tick();
        chk("unfreeze_track", state, 2);
        chk("unfrz_dc_i", $signed(dc_i), 100);

        // Saturation in both directions
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
        chk("sat_cnt_pre", sat_cnt, 0);
`endif
        set_x(-2048, 2047);
        adc_vld = 1'b1;
        tick();
        tick();
        chk("sat_out_i", $signed(out_i), -2048);
        chk("sat_out_q", $signed(out_q), 2047);
        tick();
        adc_vld = 1'b0;
        tick();
        chk("sat_out_i_last", $signed(out_i), -2048);
        chk("sat_out_q_last", $signed(out_q), 2047);
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
        chk("sat_cnt_3", sat_cnt, 3);
`endif

        // en low mid-TRACK with a sample in flight
        chk("pre_en_track", state, 2);
        set_x(7, 7);
        adc_vld = 1'b1;
        tick();
        adc_vld = 1'b0;
        en = 1'b0;
        tick();
        chk("en0_out_vld", out_vld, 0);
        chk("en0_dc_i", $signed(dc_i), 0);
        chk("en0_dc_q", $signed(dc_q), 0);
        chk("en0_state", state, 0);
`ifdef WPHY_DFE_RX_DCOC_SAT_CNT_EN
        chk("en0_sat_cnt", sat_cnt, 0);
`endif

        // FIFO full / overflow with zero estimate (FREEZE from fresh TRAIN)
        out_rdy = 1'b0;
        en = 1'b1;
        freeze = 1'b1;
        tick();
        tick();
        chk("ovf_freeze_state", state, 3);
        for (int k = 1; k <= 6; k++) begin
            set_x(10 * k, -k);
            adc_vld = 1'b1;
            tick();
            if (k == 5) chk("ovf_before_drop", ovf, 0);
            if (k == 6) chk("ovf_after_drop", ovf, 1);
        end
        adc_vld = 1'b0;
        tick();
        out_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_vld", out_vld, 1);
            chk("drain_i", $signed(out_i), 10 * k);
            chk("drain_q", $signed(out_q), -k);
            tick();
        end
        chk("drain_empty", out_vld, 0);
        chk("ovf_sticky", ovf, 1);

        // Async reset with full FIFO
        out_rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            set_x(100 + k, k);
            adc_vld = 1'b1;
            tick();
        end
        adc_vld = 1'b0;
        tick();
        chk("full_before_rst", out_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_vld", out_vld, 0);
        chk("arst_out_i", $signed(out_i), 0);
        chk("arst_out_q", $signed(out_q), 0);
        chk("arst_state", state, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_dc_i", $signed(dc_i), 0);
        rst_n = 1'b1;
        freeze = 1'b0;
        out_rdy = 1'b1;
        tick();
        chk("rst_resume_train", state, 1);

        // Freeze interrupting TRAIN keeps the sample count
        set_x(100, -50);
        adc_vld = 1'b1;
        repeat (30) tick();
        adc_vld = 1'b0;
        freeze = 1'b1;
        tick();
        chk("train_freeze", state, 3);
        adc_vld = 1'b1;
        repeat (10) tick();
        adc_vld = 1'b0;
        freeze = 1'b0;
        tick();
        chk("resume_train", state, 1);
        adc_vld = 1'b1;
        repeat (33) tick();
        chk("train_at_63_resumed", state, 1);
        tick();
        chk("track_at_64_resumed", state, 2);
        adc_vld = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
